// File: rtl/result_accumulator.sv
// Accumulates deskewed systolic result rows over K-tiles, then requantises each row
// (shift, optional ReLU, saturate) and drains it to the unified buffer.
module result_accumulator #(
  parameter int unsigned PARTIAL_SUM_BW = 20,
  parameter int unsigned MATRIX_SIZE    = 8,
  parameter int unsigned ACC_BW         = 24,
  parameter int unsigned ACC_DEPTH      = 8,
  parameter int unsigned DATA_BW        = 8,
  parameter int unsigned ADDRESSSIZE    = 10
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              start,
  input  logic [3:0]                        num_tiles,
  input  logic                              relu_en,
  input  logic [4:0]                        shift,
  input  logic [ADDRESSSIZE-1:0]            out_base_addr,
  input  logic                              in_valid,
  input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] in_data,
  output logic                              in_ready,
  output logic                              ub_we,
  output logic [ADDRESSSIZE-1:0]            ub_addr,
  output logic [DATA_BW*MATRIX_SIZE-1:0]    ub_data,
  input  logic                              ub_ready,
  output logic                              busy,
  output logic                              done
);

  localparam int unsigned RowW = (ACC_DEPTH > 1) ? $clog2(ACC_DEPTH) : 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StAccum = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam logic signed [ACC_BW:0] AccMax = {2'b00, {(ACC_BW-1){1'b1}}};
  localparam logic signed [ACC_BW:0] AccMin = {2'b11, {(ACC_BW-1){1'b0}}};
  localparam logic signed [ACC_BW-1:0] DataMax = {{(ACC_BW-DATA_BW+1){1'b0}}, {(DATA_BW-1){1'b1}}};
  localparam logic signed [ACC_BW-1:0] DataMin = {{(ACC_BW-DATA_BW+1){1'b1}}, {(DATA_BW-1){1'b0}}};

  logic [1:0]             state_q, state_d;
  logic [RowW-1:0]        row_ptr_q, row_ptr_d;
  logic [RowW-1:0]        drain_ptr_q, drain_ptr_d;
  logic [3:0]             tile_cnt_q, tile_cnt_d;
  logic [3:0]             num_tiles_q;
  logic                   relu_q;
  logic [4:0]             shift_q;
  logic [ADDRESSSIZE-1:0] base_q;

  logic signed [ACC_BW-1:0] acc_q     [ACC_DEPTH][MATRIX_SIZE];
  logic signed [ACC_BW:0]   wide_sum  [MATRIX_SIZE];
  logic signed [ACC_BW-1:0] row_sum   [MATRIX_SIZE];
  logic signed [ACC_BW-1:0] shifted   [MATRIX_SIZE];
  logic [DATA_BW-1:0]       lane_out  [MATRIX_SIZE];

  logic       beat;
  logic       last_row;
  logic       last_tile;
  logic [3:0] last_tile_idx;

  assign in_ready      = (state_q == StAccum);
  assign ub_we         = (state_q == StDrain);
  assign busy          = (state_q != StIdle);
  assign done          = (state_q == StDone);
  assign ub_addr       = ub_we ? base_q + ADDRESSSIZE'(drain_ptr_q) : '0;
  assign beat          = in_valid && in_ready;
  assign last_row      = (row_ptr_q == RowW'(ACC_DEPTH - 1));
  // A tile count of zero behaves as a single tile.
  assign last_tile_idx = (num_tiles_q == 4'd0) ? 4'd0 : num_tiles_q - 4'd1;
  assign last_tile     = (tile_cnt_q == last_tile_idx);

  // First tile overwrites the row, later tiles add into it with saturation.
  always_comb begin
    for (int i = 0; i < int'(MATRIX_SIZE); i++) begin
      wide_sum[i] = {{(ACC_BW+1-PARTIAL_SUM_BW){in_data[i*PARTIAL_SUM_BW+PARTIAL_SUM_BW-1]}},
                     in_data[i*PARTIAL_SUM_BW +: PARTIAL_SUM_BW]}
                  + ((tile_cnt_q == 4'd0) ? '0
                     : {acc_q[row_ptr_q][i][ACC_BW-1], acc_q[row_ptr_q][i]});
      if (wide_sum[i] > AccMax)      row_sum[i] = AccMax[ACC_BW-1:0];
      else if (wide_sum[i] < AccMin) row_sum[i] = AccMin[ACC_BW-1:0];
      else                           row_sum[i] = wide_sum[i][ACC_BW-1:0];
    end
  end

  always_comb begin
    ub_data = '0;
    for (int i = 0; i < int'(MATRIX_SIZE); i++) begin
      shifted[i] = acc_q[drain_ptr_q][i] >>> shift_q;
      if (relu_q && shifted[i][ACC_BW-1]) shifted[i] = '0;
      if (shifted[i] > DataMax)      lane_out[i] = DataMax[DATA_BW-1:0];
      else if (shifted[i] < DataMin) lane_out[i] = DataMin[DATA_BW-1:0];
      else                           lane_out[i] = shifted[i][DATA_BW-1:0];
      if (ub_we) ub_data[i*DATA_BW +: DATA_BW] = lane_out[i];
    end
  end

  always_comb begin
    state_d     = state_q;
    row_ptr_d   = row_ptr_q;
    tile_cnt_d  = tile_cnt_q;
    drain_ptr_d = drain_ptr_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StAccum;
          row_ptr_d  = '0;
          tile_cnt_d = '0;
        end
      end
      StAccum: begin
        if (in_valid) begin
          if (last_row) begin
            row_ptr_d = '0;
            if (last_tile) begin
              state_d     = StDrain;
              drain_ptr_d = '0;
            end else begin
              tile_cnt_d = tile_cnt_q + 4'd1;
            end
          end else begin
            row_ptr_d = row_ptr_q + RowW'(1);
          end
        end
      end
      StDrain: begin
        if (ub_ready) begin
          if (drain_ptr_q == RowW'(ACC_DEPTH - 1)) state_d = StDone;
          else                                     drain_ptr_d = drain_ptr_q + RowW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      row_ptr_q   <= '0;
      tile_cnt_q  <= '0;
      drain_ptr_q <= '0;
      num_tiles_q <= '0;
      relu_q      <= 1'b0;
      shift_q     <= '0;
      base_q      <= '0;
    end else begin
      state_q     <= state_d;
      row_ptr_q   <= row_ptr_d;
      tile_cnt_q  <= tile_cnt_d;
      drain_ptr_q <= drain_ptr_d;
      if (state_q == StIdle && start) begin
        num_tiles_q <= num_tiles;
        relu_q      <= relu_en;
        shift_q     <= shift;
        base_q      <= out_base_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int r = 0; r < int'(ACC_DEPTH); r++) begin
        for (int i = 0; i < int'(MATRIX_SIZE); i++) acc_q[r][i] <= '0;
      end
    end else if (beat) begin
      for (int i = 0; i < int'(MATRIX_SIZE); i++) acc_q[row_ptr_q][i] <= row_sum[i];
    end
  end

endmodule
